// File: rtl/ipv4_vlg_pkg.sv
// ipv4_vlg_pkg
// Shared types for the IPv4 transmit path: per-frame metadata handed from a
// client protocol (ICMP/UDP/TCP) to the IPv4 engine, the transmit arbiter
// state encoding and a small round-robin pointer helper.
package ipv4_vlg_pkg;

  // Per-frame metadata a client presents alongside its rdy request.
  typedef struct packed {
    logic [31:0] dst_ip;
    logic [7:0]  proto;
    logic [15:0] length;
  } ipv4_meta_t;

  // Transmit arbiter states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    XFER  = 2'd2
  } arb_state_t;

  // Next round-robin start position after client cur has been served.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return (cur + 32'd1 >= n) ? 32'd0 : cur + 32'd1;
  endfunction

endpackage

// File: rtl/ipv4_vlg_tx_arb_if.sv
// ipv4_vlg_tx_arb_if
// Bundles the client-side and engine-side handshake/stream signals of the
// IPv4 transmit arbiter.
//   Client side : rdy, meta, strm_dat/val/sof/eof (to arbiter); req, acc, done (from arbiter)
//   Engine side : rdy_mux, meta_mux, strm_*_mux (from arbiter); req_mux, acc_mux, done_mux (to arbiter)
// Modports: slave = the arbiter, master = the clients plus engine driving it.
interface ipv4_vlg_tx_arb_if
  import ipv4_vlg_pkg::*;
#(
  parameter int N = 3,
  parameter int W = $bits(ipv4_meta_t)
);
  logic [N-1:0]   rdy;
  logic [N*W-1:0] meta;
  logic [N*8-1:0] strm_dat;
  logic [N-1:0]   strm_val;
  logic [N-1:0]   strm_sof;
  logic [N-1:0]   strm_eof;
  logic [N-1:0]   req;
  logic [N-1:0]   acc;
  logic [N-1:0]   done;

  logic           rdy_mux;
  logic [W-1:0]   meta_mux;
  logic           req_mux;
  logic           acc_mux;
  logic           done_mux;
  logic [7:0]     strm_dat_mux;
  logic           strm_val_mux;
  logic           strm_sof_mux;
  logic           strm_eof_mux;

  modport slave (
    input  rdy, meta, strm_dat, strm_val, strm_sof, strm_eof,
    input  req_mux, acc_mux, done_mux,
    output req, acc, done,
    output rdy_mux, meta_mux, strm_dat_mux, strm_val_mux, strm_sof_mux, strm_eof_mux
  );

  modport master (
    output rdy, meta, strm_dat, strm_val, strm_sof, strm_eof,
    output req_mux, acc_mux, done_mux,
    input  req, acc, done,
    input  rdy_mux, meta_mux, strm_dat_mux, strm_val_mux, strm_sof_mux, strm_eof_mux
  );

endinterface

// File: rtl/eth_vlg_rr_pick.sv
// eth_vlg_rr_pick
// Combinational round-robin selector: returns the first asserted request at
// or after ptr, wrapping modulo N. Shared by the IPv4 and MAC arbiters.
//   req   in  N          request vector
//   ptr   in  $clog2(N)  scan start position (must be < N)
//   found out 1          at least one request asserted
//   idx   out $clog2(N)  winning index (0 when found is low)
module eth_vlg_rr_pick #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 found,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Scan N positions from ptr; the first asserted request wins.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s = IW'((int'(ptr) + k) % N);
      hit_s  = !found && req[cand_s];
      idx    = hit_s ? cand_s : idx;
      found  = found | req[cand_s];
    end
  end

endmodule

// File: rtl/ipv4_vlg_tx_arb.sv
// ipv4_vlg_tx_arb
// Round-robin transmit arbiter between the IPv4 clients and the IPv4 engine.
// One client is granted at a time; its metadata is latched and offered to
// the engine, the engine's req/acc/done handshake is routed back to that
// client only, and the client's byte stream is forwarded with one register
// stage. A watchdog aborts a transfer that does not finish within TIMEOUT
// cycles so a stalled client cannot hold the egress path.
//   clk, rst    : clock, synchronous active-high reset
//   bus (slave) : client rdy/meta/stream in, req/acc/done out;
//                 engine rdy_mux/meta_mux/stream out, req_mux/acc_mux/done_mux in
//   sel         : current grant index (debug)
//   abort       : one-cycle pulse when the watchdog fires
module ipv4_vlg_tx_arb
  import ipv4_vlg_pkg::*;
#(
  parameter int N       = 3,
  parameter int W       = $bits(ipv4_meta_t),
  parameter int TIMEOUT = 100000
) (
  input  logic                 clk,
  input  logic                 rst,
  ipv4_vlg_tx_arb_if.slave     bus,
  output logic [$clog2(N)-1:0] sel,
  output logic                 abort
);

  localparam int IW  = $clog2(N);
  localparam int WDW = $clog2(TIMEOUT + 1);

  arb_state_t     state_r;
  logic [IW-1:0]  ptr_r;
  logic [IW-1:0]  sel_r;
  logic [W-1:0]   meta_mux_r;
  logic           rdy_mux_r;
  logic [WDW-1:0] wd_r;
  logic [7:0]     dat_r;
  logic           val_r;
  logic           sof_r;
  logic           eof_r;

  logic           pick_found_s;
  logic [IW-1:0]  pick_idx_s;
  logic [N-1:0]   req_s;
  logic [N-1:0]   acc_s;
  logic [N-1:0]   done_s;
  logic           timeout_s;

  eth_vlg_rr_pick #(.N(N)) u_pick (
    .req   (bus.rdy),
    .ptr   (ptr_r),
    .found (pick_found_s),
    .idx   (pick_idx_s)
  );

  // Engine handshake routed to the granted client only; a done_mux in the
  // final watchdog cycle wins over the abort.
  always_comb begin
    req_s     = '0;
    acc_s     = '0;
    done_s    = '0;
    timeout_s = 1'b0;
    case (state_r)
      OFFER: begin
        acc_s[sel_r] = bus.acc_mux;
      end
      XFER: begin
        timeout_s     = (wd_r == WDW'(TIMEOUT - 1)) && !bus.done_mux;
        req_s[sel_r]  = bus.req_mux;
        done_s[sel_r] = bus.done_mux | timeout_s;
      end
      default: begin
      end
    endcase
  end

  // Grant FSM, metadata latch, watchdog and one-stage stream register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= '0;
      sel_r      <= '0;
      meta_mux_r <= '0;
      rdy_mux_r  <= 1'b0;
      wd_r       <= '0;
      dat_r      <= 8'd0;
      val_r      <= 1'b0;
      sof_r      <= 1'b0;
      eof_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          wd_r  <= '0;
          dat_r <= 8'd0;
          val_r <= 1'b0;
          sof_r <= 1'b0;
          eof_r <= 1'b0;
          if (pick_found_s) begin
            sel_r      <= pick_idx_s;
            meta_mux_r <= bus.meta[pick_idx_s*W +: W];
            rdy_mux_r  <= 1'b1;
            state_r    <= OFFER;
          end
        end
        OFFER: begin
          wd_r  <= '0;
          dat_r <= 8'd0;
          val_r <= 1'b0;
          sof_r <= 1'b0;
          eof_r <= 1'b0;
          if (bus.acc_mux) begin
            rdy_mux_r <= 1'b0;
            state_r   <= XFER;
          end else if (!bus.rdy[sel_r]) begin
            // Client withdrew before the engine took the frame; the pointer
            // stays put so it keeps its turn.
            rdy_mux_r <= 1'b0;
            state_r   <= IDLE;
          end
        end
        XFER: begin
          wd_r <= wd_r + WDW'(1);
          if (timeout_s) begin
            dat_r <= 8'd0;
            val_r <= 1'b0;
            sof_r <= 1'b0;
            eof_r <= 1'b0;
          end else begin
            dat_r <= bus.strm_dat[sel_r*32'd8 +: 8];
            val_r <= bus.strm_val[sel_r];
            sof_r <= bus.strm_sof[sel_r];
            eof_r <= bus.strm_eof[sel_r];
          end
          if (bus.done_mux || timeout_s) begin
            ptr_r   <= IW'(rr_next(32'(sel_r), N));
            state_r <= IDLE;
          end
        end
        default: begin
          rdy_mux_r <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req          = req_s;
  assign bus.acc          = acc_s;
  assign bus.done         = done_s;
  assign bus.rdy_mux      = rdy_mux_r;
  assign bus.meta_mux     = meta_mux_r;
  assign bus.strm_dat_mux = dat_r;
  assign bus.strm_val_mux = val_r;
  assign bus.strm_sof_mux = sof_r;
  assign bus.strm_eof_mux = eof_r;
  assign sel              = sel_r;
  assign abort            = timeout_s;

endmodule

// File: tb/tb_ipv4_vlg_tx_arb.sv
// tb_ipv4_vlg_tx_arb
// Directed bench for the IPv4 transmit arbiter (N=3, TIMEOUT=16). Inputs are
// driven 1 ns after the rising edge and outputs sampled 1-3 ns later.
module tb_ipv4_vlg_tx_arb;
  import ipv4_vlg_pkg::*;

  localparam int N       = 3;
  localparam int W       = $bits(ipv4_meta_t);
  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] sel;
  logic       abort;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m0, m1, m2, mjunk;
  logic [7:0]   bytes_q [4];

  ipv4_vlg_tx_arb_if #(.N(N), .W(W)) bus ();

  ipv4_vlg_tx_arb #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .sel   (sel),
    .abort (abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] strm_out();
    return 64'({bus.strm_dat_mux, bus.strm_val_mux, bus.strm_sof_mux, bus.strm_eof_mux});
  endfunction

  task automatic grant_chk(input int c, input logic [W-1:0] m, input string tag);
    chk({tag, "_rdy_mux"}, 64'(bus.rdy_mux), 64'd1);
    chk({tag, "_sel"}, 64'(sel), 64'(c));
    chk({tag, "_meta"}, 64'(bus.meta_mux), 64'(m));
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_rdy_mux"}, 64'(bus.rdy_mux), 64'd0);
    chk({tag, "_meta"}, 64'(bus.meta_mux), 64'd0);
    chk({tag, "_sel"}, 64'(sel), 64'd0);
    chk({tag, "_abort"}, 64'(abort), 64'd0);
    chk({tag, "_req"}, 64'(bus.req), 64'd0);
    chk({tag, "_acc"}, 64'(bus.acc), 64'd0);
    chk({tag, "_done"}, 64'(bus.done), 64'd0);
    chk({tag, "_strm"}, strm_out(), 64'd0);
  endtask

  // From an IDLE cycle with rdy set: expect grant c, accept, finish at once.
  task automatic xact_short(input int c, input logic [W-1:0] m);
    #1;
    chk("rr_idle_rdy_mux", 64'(bus.rdy_mux), 64'd0);
    chk("rr_idle_done", 64'(bus.done), 64'd0);
    tick();
    #1;
    grant_chk(c, m, "rr_grant");
    bus.acc_mux = 1'b1;
    #1;
    chk("rr_acc", 64'(bus.acc), 64'd1 << c);
    tick();
    bus.acc_mux  = 1'b0;
    bus.done_mux = 1'b1;
    #1;
    chk("rr_xfer_rdy_mux", 64'(bus.rdy_mux), 64'd0);
    chk("rr_done", 64'(bus.done), 64'd1 << c);
    chk("rr_abort", 64'(abort), 64'd0);
    tick();
    bus.done_mux = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.rdy      = '0;
    bus.meta     = '0;
    bus.strm_dat = '0;
    bus.strm_val = '0;
    bus.strm_sof = '0;
    bus.strm_eof = '0;
    bus.req_mux  = 1'b0;
    bus.acc_mux  = 1'b0;
    bus.done_mux = 1'b0;
    m0    = 56'h0A00_0001_11_0040;
    m1    = 56'hC0A8_0102_06_05DC;
    m2    = 56'hAC10_0003_01_0100;
    mjunk = 56'hFFFF_FFFF_FF_FFFF;
    bytes_q[0] = 8'hA1;
    bytes_q[1] = 8'hB2;
    bytes_q[2] = 8'hC3;
    bytes_q[3] = 8'hD4;

    // Reset state
    tick();
    tick();
    #1;
    zero_chk("reset");
    bus.meta = {m2, m1, m0};
    rst      = 1'b0;

    // Fairness: all clients requesting, grants 0,1,2
    bus.rdy = 3'b111;
    xact_short(0, m0);
    xact_short(1, m1);
    xact_short(2, m2);

    // Single client 1, accept on third cycle, 4-byte stream
    bus.rdy = 3'b010;
    #1;
    chk("sc_idle_rdy_mux", 64'(bus.rdy_mux), 64'd0);
    tick();
    #1;
    grant_chk(1, m1, "sc_grant");
    tick();
    bus.acc_mux = 1'b1;
    #1;
    chk("sc_offer_rdy_mux", 64'(bus.rdy_mux), 64'd1);
    chk("sc_acc", 64'(bus.acc), 64'h2);
    tick();
    bus.acc_mux  = 1'b0;
    bus.req_mux  = 1'b1;
    bus.meta     = {m2, mjunk, m0};
    bus.strm_dat = {8'hEE, bytes_q[0], 8'hFF};
    bus.strm_val = 3'b111;
    bus.strm_sof = 3'b111;
    bus.strm_eof = 3'b101;
    #1;
    chk("sc_req", 64'(bus.req), 64'h2);
    chk("sc_acc_gone", 64'(bus.acc), 64'd0);
    chk("sc_xfer_rdy_mux", 64'(bus.rdy_mux), 64'd0);
    chk("sc_no_early_val", 64'(bus.strm_val_mux), 64'd0);
    chk("sc_meta_hold", 64'(bus.meta_mux), 64'(m1));
    for (int b = 1; b <= 4; b++) begin
      tick();
      if (b < 4) begin
        bus.strm_dat = {8'hEE, bytes_q[b], 8'hFF};
        bus.strm_val = 3'b111;
        bus.strm_sof = 3'b101;
        bus.strm_eof = {1'b1, (b == 3), 1'b1};
      end else begin
        bus.strm_dat = {8'hEE, 8'h00, 8'hFF};
        bus.strm_val = 3'b101;
        bus.strm_sof = 3'b101;
        bus.strm_eof = 3'b101;
        bus.done_mux = 1'b1;
        bus.req_mux  = 1'b0;
      end
      #1;
      chk("sc_stream", strm_out(), 64'({bytes_q[b-1], 1'b1, (b == 1), (b == 4)}));
    end
    chk("sc_done", 64'(bus.done), 64'h2);
    chk("sc_abort", 64'(abort), 64'd0);
    tick();
    bus.done_mux = 1'b0;
    bus.meta     = {m2, m1, m0};
    bus.rdy      = 3'b110;
    bus.strm_dat = '0;
    bus.strm_val = '0;
    bus.strm_sof = '0;
    bus.strm_eof = '0;
    #1;
    chk("sc_done_gone", 64'(bus.done), 64'd0);
    chk("sc_stream_idle", strm_out(), 64'd0);
    chk("sc_no_reoffer", 64'(bus.rdy_mux), 64'd0);
    tick();
    #1;
    grant_chk(2, m2, "ptr_adv");

    // Withdrawal of client 2 during OFFER
    bus.rdy = 3'b001;
    #1;
    chk("wd_offer_rdy_mux", 64'(bus.rdy_mux), 64'd1);
    tick();
    #1;
    chk("wd_drop_rdy_mux", 64'(bus.rdy_mux), 64'd0);
    chk("wd_drop_acc", 64'(bus.acc), 64'd0);
    tick();
    #1;
    grant_chk(0, m0, "wd_regrant");

    // Watchdog timeout on client 0
    bus.acc_mux = 1'b1;
    #1;
    chk("to_acc", 64'(bus.acc), 64'h1);
    tick();
    bus.acc_mux  = 1'b0;
    bus.strm_dat = {8'hEE, 8'hFF, 8'h55};
    bus.strm_val = 3'b001;
    #1;
    for (int k = 1; k < TIMEOUT; k++) begin
      chk("to_run_abort", 64'(abort), 64'd0);
      chk("to_run_done", 64'(bus.done), 64'd0);
      tick();
      #1;
    end
    chk("to_abort", 64'(abort), 64'd1);
    chk("to_done", 64'(bus.done), 64'h1);
    chk("to_stream_live", strm_out(), 64'({8'h55, 1'b1, 1'b0, 1'b0}));
    bus.rdy = 3'b111;
    tick();
    bus.strm_dat = '0;
    bus.strm_val = '0;
    #1;
    chk("to_clear", strm_out(), 64'd0);
    chk("to_abort_gone", 64'(abort), 64'd0);
    chk("to_done_gone", 64'(bus.done), 64'd0);
    chk("to_idle_rdy_mux", 64'(bus.rdy_mux), 64'd0);
    tick();
    #1;
    grant_chk(1, m1, "to_next");

    // done_mux coinciding with the last watchdog cycle
    bus.acc_mux = 1'b1;
    #1;
    chk("sim_acc", 64'(bus.acc), 64'h2);
    tick();
    bus.acc_mux = 1'b0;
    #1;
    for (int k = 1; k < TIMEOUT; k++) begin
      tick();
      #1;
    end
    bus.done_mux = 1'b1;
    #1;
    chk("sim_done", 64'(bus.done), 64'h2);
    chk("sim_abort", 64'(abort), 64'd0);
    tick();
    bus.done_mux = 1'b0;
    #1;
    chk("sim_abort_after", 64'(abort), 64'd0);
    chk("sim_done_gone", 64'(bus.done), 64'd0);
    tick();
    #1;
    grant_chk(2, m2, "sim_next");

    // Reset in the middle of a transfer
    bus.acc_mux = 1'b1;
    #1;
    chk("rst_acc", 64'(bus.acc), 64'h4);
    tick();
    bus.acc_mux  = 1'b0;
    bus.req_mux  = 1'b1;
    bus.strm_dat = {8'h77, 8'hEE, 8'hFF};
    bus.strm_val = 3'b111;
    #1;
    chk("rst_req", 64'(bus.req), 64'h4);
    tick();
    #1;
    chk("rst_stream_live", strm_out(), 64'({8'h77, 1'b1, 1'b0, 1'b0}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    zero_chk("rst_mid");
    bus.req_mux  = 1'b0;
    bus.strm_dat = '0;
    bus.strm_val = '0;
    tick();
    #1;
    grant_chk(0, m0, "rst_regrant");

    bus.rdy = '0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
